// File: rtl/squeeze_pingpong_writer.sv
// squeeze_pingpong_writer: write side of the squeeze 1x1 layer.
// Buffers packed 8-filter beats in a small FIFO and writes each one into
// one half of a 16-channel ping-pong feature-memory word, advancing a
// (group, line, col) raster position per write. The bank toggles at layer end.
// Optional build macro: SQW_RELU_EN (fused ReLU on every 16-bit lane).
module squeeze_pingpong_writer #(
  parameter int DW     = 16,
  parameter int NF     = 8,
  parameter int NCH    = 16,
  parameter int AW     = 32,
  parameter int FDEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [2:0]          firesel,
  input  logic                in_valid,
  input  logic [NF*DW-1:0]    in_data,
  output logic                in_ready,
  output logic                wr_en,
  input  logic                wr_ready,
  output logic [AW-1:0]       wr_addr,
  output logic [NCH*DW-1:0]   wr_data,
  output logic [1:0]          wr_be,
  output logic                bank_sel,
  output logic                busy,
  output logic                done,
  output logic                overflow_err
);

  localparam int HW = NF * DW;
  localparam int PW = $clog2(FDEPTH);
  localparam logic [PW:0]   PTR_ONE = {{PW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] AW_ONE  = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Feature-map side length for a layer select.
  function automatic logic [5:0] cfg_side(input logic [2:0] sel);
    logic [5:0] s;
    case (sel)
      3'd0, 3'd1: s = 6'd55;
      3'd2, 3'd3: s = 6'd27;
      default:    s = 6'd13;
    endcase
    return s;
  endfunction

  // Number of 8-filter groups (F/8) for a layer select.
  function automatic logic [3:0] cfg_groups(input logic [2:0] sel);
    logic [3:0] g;
    case (sel)
      3'd0, 3'd1: g = 4'd2;
      3'd2, 3'd3: g = 4'd4;
      3'd4, 3'd5: g = 4'd6;
      default:    g = 4'd8;
    endcase
    return g;
  endfunction

  // Lane conditioning before packing: negative lanes clamp to zero when the
  // fused ReLU is built in, otherwise data passes untouched.
  function automatic logic [HW-1:0] lane_cond(input logic [HW-1:0] d);
    logic [HW-1:0] r;
    r = d;
`ifdef SQW_RELU_EN
    for (int i = 0; i < NF; i++) begin
      if (d[i*DW + DW - 1]) begin
        r[i*DW +: DW] = {DW{1'b0}};
      end else begin
        r[i*DW +: DW] = d[i*DW +: DW];
      end
    end
`endif
    return r;
  endfunction

  state_t          state_r;
  logic [5:0]      s_r;
  logic [AW-1:0]   sq_r;
  logic [AW-1:0]   total_r;
  logic [AW-1:0]   accepted_r;
  logic [5:0]      col_r;
  logic [5:0]      line_r;
  logic [2:0]      grp_r;
  logic [HW-1:0]   fifo_mem_r [FDEPTH];
  logic [PW:0]     wptr_r;
  logic [PW:0]     rptr_r;

  logic            fifo_full_s;
  logic            fifo_empty_s;
  logic            push_s;
  logic            pop_s;
  logic [AW-1:0]   addr_s;
  logic [HW-1:0]   lane_s;
  logic [5:0]      start_side_s;
  logic [AW-1:0]   start_sq_s;
  logic [AW-1:0]   start_total_s;

  assign fifo_empty_s  = (wptr_r == rptr_r);
  assign fifo_full_s   = (wptr_r[PW] != rptr_r[PW]) && (wptr_r[PW-1:0] == rptr_r[PW-1:0]);
  // Ready is built only from registered state, so it is glitch-free and
  // deliberately ignores a same-cycle pop when the FIFO is full.
  assign in_ready      = (state_r == ST_RUN) && !fifo_full_s && (accepted_r < total_r);
  assign push_s        = in_valid && in_ready;
  // A new entry enters the write register whenever it is empty or being accepted.
  assign pop_s         = !fifo_empty_s && (!wr_en || wr_ready);
  assign addr_s        = AW'(grp_r[2:1]) * sq_r + AW'(line_r) * AW'(s_r) + AW'(col_r);
  assign lane_s        = lane_cond(fifo_mem_r[rptr_r[PW-1:0]]);
  assign start_side_s  = cfg_side(firesel);
  assign start_sq_s    = AW'(start_side_s) * AW'(start_side_s);
  assign start_total_s = AW'(cfg_groups(firesel)) * start_sq_s;

  // FIFO storage: payload only, emptiness is carried by the pointers.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wptr_r[PW-1:0]] <= in_data;
    end
  end

  // Layer FSM, FIFO pointers, raster counters and registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      s_r          <= 6'd0;
      sq_r         <= {AW{1'b0}};
      total_r      <= {AW{1'b0}};
      accepted_r   <= {AW{1'b0}};
      col_r        <= 6'd0;
      line_r       <= 6'd0;
      grp_r        <= 3'd0;
      wptr_r       <= {(PW+1){1'b0}};
      rptr_r       <= {(PW+1){1'b0}};
      wr_en        <= 1'b0;
      wr_addr      <= {AW{1'b0}};
      wr_data      <= {(NCH*DW){1'b0}};
      wr_be        <= 2'b00;
      bank_sel     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      done <= 1'b0;

      if (push_s) begin
        wptr_r     <= wptr_r + PTR_ONE;
        accepted_r <= accepted_r + AW_ONE;
      end

      // Counters track the entry being loaded; the load order equals write order.
      if (pop_s) begin
        rptr_r  <= rptr_r + PTR_ONE;
        wr_en   <= 1'b1;
        wr_addr <= addr_s;
        wr_be   <= grp_r[0] ? 2'b10 : 2'b01;
        wr_data <= grp_r[0] ? {lane_s, {HW{1'b0}}} : {{HW{1'b0}}, lane_s};
        if (col_r == s_r - 6'd1) begin
          col_r <= 6'd0;
          if (line_r == s_r - 6'd1) begin
            line_r <= 6'd0;
            grp_r  <= grp_r + 3'd1;
          end else begin
            line_r <= line_r + 6'd1;
          end
        end else begin
          col_r <= col_r + 6'd1;
        end
      end else if (wr_en && wr_ready) begin
        wr_en <= 1'b0;
      end

      case (state_r)
        ST_IDLE: begin
          if (start) begin
            s_r          <= start_side_s;
            sq_r         <= start_sq_s;
            total_r      <= start_total_s;
            accepted_r   <= {AW{1'b0}};
            col_r        <= 6'd0;
            line_r       <= 6'd0;
            grp_r        <= 3'd0;
            overflow_err <= 1'b0;
            busy         <= 1'b1;
            state_r      <= ST_RUN;
          end else if (in_valid) begin
            overflow_err <= 1'b1;
          end
        end
        ST_RUN: begin
          if (push_s && (accepted_r == total_r - AW_ONE)) begin
            state_r <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Last write: FIFO already empty and the held word is accepted now.
          if (wr_en && wr_ready && fifo_empty_s) begin
            state_r  <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b1;
            bank_sel <= ~bank_sel;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_squeeze_pingpong_writer.sv
// Scoreboard bench for squeeze_pingpong_writer: accepted beats push the
// expected memory write (address from plain div/mod raster arithmetic),
// a negedge monitor pops and compares every accepted write.
module tb_squeeze_pingpong_writer;

  localparam int DW = 16, NF = 8, NCH = 16, AW = 32, FDEPTH = 4;

  logic               clk = 1'b0;
  logic               rst, start, in_valid, in_ready, wr_en, wr_ready;
  logic [2:0]         firesel;
  logic [NF*DW-1:0]   in_data;
  logic [AW-1:0]      wr_addr;
  logic [NCH*DW-1:0]  wr_data;
  logic [1:0]         wr_be;
  logic               bank_sel, busy, done, overflow_err;

  squeeze_pingpong_writer #(.DW(DW), .NF(NF), .NCH(NCH), .AW(AW), .FDEPTH(FDEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .firesel(firesel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .bank_sel(bank_sel), .busy(busy), .done(done),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int cur_s, cur_g, total, pushed, completed, done_cnt;
  bit layer_active, hs_in, stall_pending, exp_bank;
  logic [AW-1:0]     held_addr;
  logic [NCH*DW-1:0] held_data;
  logic [1:0]        held_be;
  logic [AW-1:0]     q_addr[$];
  logic [NCH*DW-1:0] q_data[$];
  logic [1:0]        q_be[$];

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int side_of(input int sel);
    return (sel < 2) ? 55 : (sel < 4) ? 27 : 13;
  endfunction

  function automatic int groups_of(input int sel);
    int f;
    f = (sel < 2) ? 16 : (sel < 4) ? 32 : (sel < 6) ? 48 : 64;
    return f / 8;
  endfunction

  function automatic logic [NCH*DW-1:0] exp_word(input logic [NF*DW-1:0] d, input int grp);
    logic [NF*DW-1:0] v;
    logic [NF*DW-1:0] z;
    v = d;
    z = '0;
`ifdef SQW_RELU_EN
    for (int i = 0; i < NF; i++) if (v[i*DW + DW - 1]) v[i*DW +: DW] = 16'h0000;
`endif
    return (grp % 2 == 1) ? {v, z} : {z, v};
  endfunction

  // Monitor: input acceptance feeds the scoreboard, write acceptance drains it.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      int occ, plane, grp, rem, line, col;
      occ = pushed - completed - int'(wr_en);
      if (layer_active) check("in_ready", in_ready, (occ < FDEPTH) && (pushed < total));
      else              check("in_ready_idle", in_ready, 1'b0);
      hs_in = in_valid && in_ready;
      if (hs_in) begin
        plane = cur_s * cur_s;
        grp   = pushed / plane;
        rem   = pushed % plane;
        line  = rem / cur_s;
        col   = rem % cur_s;
        q_addr.push_back(AW'((grp / 2) * plane + line * cur_s + col));
        q_be.push_back((grp % 2 == 1) ? 2'b10 : 2'b01);
        q_data.push_back(exp_word(in_data, grp));
        pushed++;
      end
      if (wr_en) begin
        if (stall_pending) begin
          check("stall_addr", wr_addr, held_addr);
          check("stall_data", wr_data, held_data);
          check("stall_be", wr_be, held_be);
        end
        if (wr_ready) begin
          stall_pending = 1'b0;
          if (q_addr.size() == 0) begin
            check("write_unexpected", 1'b1, 1'b0);
          end else begin
            check("wr_addr", wr_addr, q_addr.pop_front());
            check("wr_be", wr_be, q_be.pop_front());
            check("wr_data", wr_data, q_data.pop_front());
            completed++;
          end
        end else begin
          stall_pending = 1'b1;
          held_addr = wr_addr;
          held_data = wr_data;
          held_be   = wr_be;
        end
      end else if (stall_pending) begin
        check("wr_en_dropped", 1'b0, 1'b1);
        stall_pending = 1'b0;
      end
      if (done) begin
        done_cnt++;
        check("done_at_last_write", completed, total);
      end
    end
  end

  function automatic logic next_ready(input int rmode, input logic cur);
    if (rmode == 0) return 1'b1;
    if (rmode == 1) return ~cur;
    return ($urandom_range(0, 3) != 0);
  endfunction

  // One layer: start, feed all beats (optionally aborting by reset or pulsing
  // a second start mid-layer), then wait for done and check the layer end.
  task automatic run_layer(input int sel, input int rmode, input int vmode,
                           input int abort_at, input int mid_start);
    int cyc;
    bit did_mid;
    cur_s = side_of(sel);
    cur_g = groups_of(sel);
    total = cur_g * cur_s * cur_s;
    pushed = 0; completed = 0; done_cnt = 0;
    stall_pending = 1'b0; hs_in = 1'b0; did_mid = 1'b0;
    q_addr.delete(); q_data.delete(); q_be.delete();
    firesel = 3'(sel);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    layer_active = 1'b1;
    check("overflow_cleared", overflow_err, 1'b0);
    check("busy_after_start", busy, 1'b1);
    cyc = 0;
    while (pushed < total && cyc < 40000) begin
      if (abort_at > 0 && pushed >= abort_at) begin
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        stall_pending = 1'b0;
        layer_active = 1'b0;
        exp_bank = 1'b0;
        check("abort_wr_en", wr_en, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_bank_sel", bank_sel, 1'b0);
        check("abort_in_ready", in_ready, 1'b0);
        return;
      end
      if (mid_start > 0 && pushed == mid_start && !did_mid) begin
        start = 1'b1;
        firesel = 3'd0;
        did_mid = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (!(in_valid && !hs_in)) begin
        in_valid = (vmode == 1) ? 1'b1 : ($urandom_range(0, 2) != 0);
        in_data = {$urandom, $urandom, $urandom, $urandom};
        if (pushed == 0) in_data[31:0] = {16'h0005, 16'hFFF0};
      end
      wr_ready = next_ready(rmode, wr_ready);
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    if (pushed < total) check("feed_timeout", pushed, total);
    cyc = 0;
    while (done_cnt == 0 && cyc < 30000) begin
      wr_ready = next_ready(rmode, wr_ready);
      @(posedge clk); #1;
      cyc++;
    end
    if (done_cnt == 0) check("done_timeout", 1'b0, 1'b1);
    exp_bank = ~exp_bank;
    wr_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("done_count", done_cnt, 1);
    check("writes_completed", completed, total);
    check("scoreboard_empty", q_addr.size(), 0);
    check("busy_after_done", busy, 1'b0);
    check("bank_sel", bank_sel, exp_bank);
    check("wr_en_after_done", wr_en, 1'b0);
    layer_active = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; firesel = 3'd0; in_valid = 1'b0;
    in_data = '0; wr_ready = 1'b1; exp_bank = 1'b0; layer_active = 1'b0;
    total = 0; pushed = 0; completed = 0; done_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_wr_en", wr_en, 1'b0);
    check("rst_wr_addr", wr_addr, 32'd0);
    check("rst_wr_data", wr_data, 256'd0);
    check("rst_wr_be", wr_be, 2'b00);
    check("rst_bank_sel", bank_sel, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_overflow", overflow_err, 1'b0);
    rst = 1'b0;

    // Input valid while idle: sticky error, no write, no ready.
    in_valid = 1'b1;
    in_data = {4{32'hDEADBEEF}};
    repeat (5) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    check("overflow_set", overflow_err, 1'b1);
    check("idle_no_write", wr_en, 1'b0);
    check("idle_busy", busy, 1'b0);

    // firesel 4, full-rate write side.
    run_layer(4, 0, 0, 0, 0);
    // firesel 4 again, random backpressure, ignored start mid-layer.
    run_layer(4, 2, 0, 0, 300);
    // firesel 0, write ready toggling, input always valid (FIFO fills).
    run_layer(0, 1, 1, 0, 0);
    // firesel 2 aborted by reset after 100 beats, then a clean rerun.
    run_layer(2, 0, 1, 100, 0);
    run_layer(2, 2, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
